truth_table_sweeper: RTL and testbench

//   Sequencer that exhaustively exercises a combinational N-input boolean unit (e.g. a 4-var POS/SOP

---
 rtl/truth_table_sweeper_pkg.sv | 24 ++
 rtl/truth_table_sweeper_settle_timer.sv | 42 ++++
 rtl/truth_table_sweeper.sv | 155 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper.
//
// Contents:
//   DEFAULT_N_INPUTS      default number of inputs on the unit under exercise
//   DEFAULT_SETTLE_CYCLES default hold time for each vector before it is sampled
//   sweep_state_t         sequencer states, 2-bit: IDLE=0, APPLY=1, SAMPLE=2, DONE=3
//   table_depth()         number of rows in a truth table with n inputs
package truth_table_sweeper_pkg;

    localparam int DEFAULT_N_INPUTS      = 4;
    localparam int DEFAULT_SETTLE_CYCLES = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

    function automatic int table_depth(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter that measures how long a vector is held on the unit
// before its output is trusted.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-high; clears the count
//   load    reloads the count with LOAD_VALUE (asserted on APPLY entry)
//   enable  counts down one step per cycle while high
//   expire  high during the enabled cycle whose closing edge takes the count to 0
module truth_table_sweeper_settle_timer #(
    parameter int LOAD_VALUE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(LOAD_VALUE + 1);
    localparam logic [CW-1:0] LOAD_CNT = CW'(LOAD_VALUE);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic [CW-1:0] count;

    // Count register: a load wins over counting so back-to-back vectors
    // restart cleanly; the count parks at zero once exhausted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_CNT;
        end else if (enable && (count != '0)) begin
            count <= count - ONE_CNT;
        end
    end

    // Flagging expiry one step early lets the FSM leave APPLY on exactly the
    // edge where the count reaches zero, giving LOAD_VALUE cycles of APPLY.
    assign expire = enable && (count == ONE_CNT);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sequencer that exhaustively drives a combinational N-input boolean unit
// through every input vector 0..2**N-1 (MSB first, {x,y,w,z} for N=4),
// samples its output after a settle time and compares it with a truth table
// latched when the sweep is accepted.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high; clears all state immediately
//   start          one-cycle sweep request, honoured only in IDLE or DONE
//   expected       expected output per vector, bit i = F(i); latched on accept
//   dut_in         vector driven to the unit
//   dut_out        unit output, sampled only in SAMPLE
//   busy           high from accepted start until done rises
//   done           high after the last vector, until the next accept or reset
//   pass           valid while done: 1 when no vector mismatched
//   mismatch_mask  bit i set when the sampled F(i) differed from expected[i]
//   err_count      number of mismatching vectors (0..2**N)
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_INPUTS      = DEFAULT_N_INPUTS,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    localparam int DEPTH        = table_depth(N_INPUTS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DEPTH-1:0]    expected,
    output logic [N_INPUTS-1:0] dut_in,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [DEPTH-1:0]    mismatch_mask,
    output logic [N_INPUTS:0]   err_count
);

    localparam logic [N_INPUTS-1:0] LAST_IDX = {N_INPUTS{1'b1}};
    localparam logic [N_INPUTS-1:0] IDX_ONE  = N_INPUTS'(1);

    sweep_state_t        state;
    sweep_state_t        next_state;
    logic [N_INPUTS-1:0] idx;
    logic [DEPTH-1:0]    latched;
    logic                accept;
    logic                sample_now;
    logic                last_vec;
    logic                mismatch;
    logic [N_INPUTS:0]   err_next;
    logic                timer_load;
    logic                timer_en;
    logic                timer_expire;

    truth_table_sweeper_settle_timer #(
        .LOAD_VALUE(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .enable(timer_en),
        .expire(timer_expire)
    );

    // The vector register doubles as the unit drive, so the unit only sees a
    // change on the edge that enters APPLY.
    assign dut_in   = idx;
    assign last_vec = (idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode. Starts are only decoded in IDLE/DONE,
    // which is what makes a start during a sweep harmless.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        sample_now = 1'b0;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                done = (state == ST_DONE);
                if (start) begin
                    accept     = 1'b1;
                    timer_load = 1'b1;
                    next_state = ST_APPLY;
                end
            end
            ST_APPLY: begin
                busy     = 1'b1;
                timer_en = 1'b1;
                if (timer_expire) begin
                    next_state = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                busy       = 1'b1;
                sample_now = 1'b1;
                if (last_vec) begin
                    next_state = ST_DONE;
                end else begin
                    timer_load = 1'b1;
                    next_state = ST_APPLY;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // The final pass flag has to include the last vector's result, so it is
    // derived from the count as it will be after this compare.
    always_comb begin
        mismatch = sample_now && (dut_out != latched[idx]);
        err_next = err_count + (N_INPUTS + 1)'(mismatch);
    end

    // Datapath: latched table, vector index and result accumulation. The
    // count is one bit wider than the index so a fully failing table fits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx           <= '0;
            latched       <= '0;
            mismatch_mask <= '0;
            err_count     <= '0;
            pass          <= 1'b0;
        end else if (accept) begin
            idx           <= '0;
            latched       <= expected;
            mismatch_mask <= '0;
            err_count     <= '0;
            pass          <= 1'b0;
        end else if (sample_now) begin
            if (mismatch) begin
                mismatch_mask[idx] <= 1'b1;
            end
            err_count <= err_next;
            if (last_vec) begin
                pass <= (err_next == '0);
            end else begin
                idx <= idx + IDX_ONE;
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper. Two instances share one clock
// and reset: one with a one-cycle settle, one with a three-cycle settle. The
// boolean unit is modelled in the bench as a lookup into unit_table, with an
// optional two-cycle output delay per instance.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [15:0] expected_a, expected_b;
    logic [3:0]  dut_in_a, dut_in_b;
    logic        dut_out_a, dut_out_b;
    logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [15:0] mask_a, mask_b;
    logic [4:0]  err_a, err_b;

    logic [15:0] unit_table;
    bit          delay_a, delay_b;
    logic [3:0]  a_d1, a_d2, b_d1, b_d2;
    bit          use_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_INPUTS(4), .SETTLE_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .expected(expected_a),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .mismatch_mask(mask_a), .err_count(err_a)
    );

    truth_table_sweeper #(.N_INPUTS(4), .SETTLE_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .expected(expected_b),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .mismatch_mask(mask_b), .err_count(err_b)
    );

    // Unit model: F(v) = unit_table[v], optionally seen two cycles late.
    always @(posedge clk) begin
        a_d1 <= dut_in_a;
        a_d2 <= a_d1;
        b_d1 <= dut_in_b;
        b_d2 <= b_d1;
    end
    assign dut_out_a = delay_a ? unit_table[a_d2] : unit_table[dut_in_a];
    assign dut_out_b = delay_b ? unit_table[b_d2] : unit_table[dut_in_b];

    wire [3:0]  sel_dut_in = use_b ? dut_in_b : dut_in_a;
    wire        sel_busy   = use_b ? busy_b   : busy_a;
    wire        sel_done   = use_b ? done_b   : done_a;
    wire        sel_pass   = use_b ? pass_b   : pass_a;
    wire [15:0] sel_mask   = use_b ? mask_b   : mask_a;
    wire [4:0]  sel_err    = use_b ? err_b    : err_a;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] required);
        checks++;
        if (observed !== required) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, required);
        end
    endtask

    task automatic set_start(input bit value);
        if (use_b) start_b = value;
        else       start_a = value;
    endtask

    // One sweep: accept on the next edge, then watch dut_in step through the
    // vectors (vector c/(settle+1) after c cycles) until done, bounded.
    task automatic apply_stimulus(input bit inst_b, input logic [15:0] exp,
                                  input bit glitch, output int lat, output int order_bad);
        int settle;
        int limit;
        use_b  = inst_b;
        settle = inst_b ? 3 : 1;
        limit  = 16 * (settle + 1) + 20;
        @(negedge clk);
        if (inst_b) expected_b = exp;
        else        expected_a = exp;
        set_start(1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0);
        if (inst_b) expected_b = 16'($urandom);
        else        expected_a = 16'($urandom);
        lat       = -1;
        order_bad = 0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (sel_done) begin
                lat = c;
                break;
            end
            if (sel_dut_in != 4'(c / (settle + 1))) order_bad++;
            if (!sel_busy) order_bad++;
            if (glitch && (c == 4 || c == 19)) set_start(1'b1);
            @(posedge clk);
            #1;
            set_start(1'b0);
        end
        set_start(1'b0);
    endtask

    // Expected results of a sweep with an immediate unit: a vector fails
    // exactly where the unit's table and the expected table disagree.
    task automatic check_results(input string tag, input logic [15:0] exp);
        logic [15:0] want_mask;
        int          want_err;
        want_mask = unit_table ^ exp;
        want_err  = $countones(want_mask);
        check_output({tag, "_mask"}, sel_mask, want_mask);
        check_output({tag, "_err"},  sel_err, want_err);
        check_output({tag, "_pass"}, sel_pass, want_err == 0);
        check_output({tag, "_busy"}, sel_busy, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_dut_in"}, dut_in_a, 4'd0);
        check_output({tag, "_busy"},   busy_a,   1'b0);
        check_output({tag, "_done"},   done_a,   1'b0);
        check_output({tag, "_pass"},   pass_a,   1'b0);
        check_output({tag, "_mask"},   mask_a,   16'h0);
        check_output({tag, "_err"},    err_a,    5'd0);
    endtask

    initial begin : main
        int          lat;
        int          order_bad;
        int          maxterms[8] = '{0, 1, 2, 4, 6, 8, 11, 14};
        logic [15:0] f_table;
        logic [15:0] exp;
        logic [4:0]  err_snap;

        reset      = 1'b1;
        start_a    = 1'b0;
        start_b    = 1'b0;
        expected_a = '0;
        expected_b = '0;
        delay_a    = 1'b0;
        delay_b    = 1'b0;
        use_b      = 1'b0;

        // F is 0 on its maxterms and 1 everywhere else.
        f_table = '1;
        foreach (maxterms[i]) f_table[maxterms[i]] = 1'b0;
        unit_table = f_table;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("por");
        reset = 1'b0;

        // Correct table for the product-of-maxterms unit.
        apply_stimulus(1'b0, 16'hB6A8, 1'b0, lat, order_bad);
        check_output("t2_latency", lat, 32);
        check_output("t2_order", order_bad, 0);
        check_results("t2", 16'hB6A8);
        err_snap = err_a;
        repeat (3) @(negedge clk);
        check_output("t2_done_held", done_a, 1'b1);
        check_output("t2_err_held", err_a, err_snap);

        // One flipped bit.
        apply_stimulus(1'b0, 16'hB6A9, 1'b0, lat, order_bad);
        check_output("t3_latency", lat, 32);
        check_results("t3", 16'hB6A9);

        // Unit tied to 0 against an all-ones table: full count, no wrap.
        unit_table = 16'h0000;
        apply_stimulus(1'b0, 16'hFFFF, 1'b0, lat, order_bad);
        check_output("t4_latency", lat, 32);
        check_results("t4", 16'hFFFF);

        // Starts mid-sweep are ignored.
        unit_table = f_table;
        apply_stimulus(1'b0, 16'hB6A8, 1'b1, lat, order_bad);
        check_output("t5_latency", lat, 32);
        check_output("t5_order", order_bad, 0);
        check_results("t5", 16'hB6A8);

        // Asynchronous reset mid-sweep with errors already accumulated.
        unit_table = 16'h0000;
        @(negedge clk);
        expected_a = 16'hFFFF;
        start_a    = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        reset = 1'b0;
        unit_table = f_table;
        apply_stimulus(1'b0, 16'hB6A8, 1'b0, lat, order_bad);
        check_output("postrst_latency", lat, 32);
        check_output("postrst_order", order_bad, 0);
        check_results("postrst", 16'hB6A8);

        // Random units against random tables, some exactly right.
        for (int i = 0; i < 10; i++) begin
            unit_table = 16'($urandom);
            exp = (i % 3 == 0) ? unit_table : 16'($urandom);
            apply_stimulus(1'b0, exp, 1'b0, lat, order_bad);
            check_output($sformatf("rnd%0d_latency", i), lat, 32);
            check_results($sformatf("rnd%0d", i), exp);
        end

        // Slow unit: a three-cycle settle covers the delay, one cycle does not.
        unit_table = f_table;
        delay_b    = 1'b1;
        apply_stimulus(1'b1, 16'hB6A8, 1'b0, lat, order_bad);
        check_output("t6_s3_latency", lat, 64);
        check_output("t6_s3_order", order_bad, 0);
        check_results("t6_s3", 16'hB6A8);

        delay_a = 1'b1;
        apply_stimulus(1'b0, 16'hB6A8, 1'b0, lat, order_bad);
        check_output("t6_s1_latency", lat, 32);
        check_output("t6_s1_pass", pass_a, 1'b0);
        check_output("t6_s1_err_nonzero", err_a != 5'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
